// File: rtl/block_swap_ctrl_pkg.sv
// Shared types and sizes for the transparent-SPI block-swap controller.
package block_swap_ctrl_pkg;

  localparam int NUM_SRAM_ADDRESSES = 8;
  localparam int BLOCK_TAG_W        = 21;
  localparam int SLOT_IDX_W         = $clog2(NUM_SRAM_ADDRESSES);

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [BLOCK_TAG_W-1:0] tag;
  } slot_entry_t;

  typedef struct packed {
    logic                   wb;
    logic [BLOCK_TAG_W-1:0] wb_tag;
    logic [BLOCK_TAG_W-1:0] fetch_tag;
    logic [SLOT_IDX_W-1:0]  slot;
  } swap_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } swap_state_e;

endpackage

// File: rtl/block_swap_ctrl_if.sv
// Manager-port lookup and swap-engine command bundle of block_swap_ctrl.
interface block_swap_ctrl_if;
  import block_swap_ctrl_pkg::*;

  logic [BLOCK_TAG_W-1:0] req_tag_i;
  logic                   req_valid_i;
  logic                   req_we_i;
  logic                   req_gnt_i;
  logic                   block_o;
  logic [SLOT_IDX_W-1:0]  slot_idx_o;
  logic                   swap_req_o;
  logic                   swap_gnt_i;
  logic                   swap_done_i;
  logic                   swap_wb_o;
  logic [BLOCK_TAG_W-1:0] swap_wb_tag_o;
  logic [BLOCK_TAG_W-1:0] swap_fetch_tag_o;
  logic [SLOT_IDX_W-1:0]  swap_slot_o;
  logic                   busy_o;

  modport slave (
    input  req_tag_i, req_valid_i, req_we_i, req_gnt_i, swap_gnt_i, swap_done_i,
    output block_o, slot_idx_o, swap_req_o, swap_wb_o, swap_wb_tag_o,
           swap_fetch_tag_o, swap_slot_o, busy_o
  );

  modport master (
    output req_tag_i, req_valid_i, req_we_i, req_gnt_i, swap_gnt_i, swap_done_i,
    input  block_o, slot_idx_o, swap_req_o, swap_wb_o, swap_wb_tag_o,
           swap_fetch_tag_o, swap_slot_o, busy_o
  );

endinterface

// File: rtl/block_swap_ctrl_chk.sv
// Table invariants: at most one hitting slot and no tag resident twice.
module block_swap_ctrl_chk #(
  parameter int NumSlots = 8,
  parameter int TagWidth = 21
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic [NumSlots-1:0] valid,
  input logic [TagWidth-1:0] tags [NumSlots],
  input logic [NumSlots-1:0] hit_vec
);

  logic dup_s;

  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      for (int j = i + 1; j < NumSlots; j++) begin
        dup_s = dup_s | (valid[i] & valid[j] & (tags[i] == tags[j]));
      end
    end
  end

  as_onehot_hit: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(hit_vec));
  as_no_dup_tag: assert property (@(posedge clk_i) disable iff (!rst_ni) !dup_s);

endmodule

// File: rtl/block_swap_tag_table.sv
// Resident-slot table: tag compare, first-invalid victim search, round-robin pointer.
// Dirty bits exist only when BLOCK_SWAP_DIRTY_EN is defined.
module block_swap_tag_table import block_swap_ctrl_pkg::*; #(
  parameter int  NumSlots = NUM_SRAM_ADDRESSES,
  parameter int  TagWidth = BLOCK_TAG_W,
  localparam int IdxW     = $clog2(NumSlots)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [TagWidth-1:0] lookup_tag,
  output logic                hit,
  output logic [IdxW-1:0]     hit_idx,
  output logic [IdxW-1:0]     victim_idx,
  output logic                victim_wb,
  output logic [TagWidth-1:0] victim_tag,
  output logic                victim_is_ptr,
  input  logic                inval_en,
  input  logic [IdxW-1:0]     inval_slot,
  input  logic                fill_en,
  input  logic [IdxW-1:0]     fill_slot,
  input  logic [TagWidth-1:0] fill_tag,
  input  logic                fill_adv_ptr,
  input  logic                dirty_set_en,
  input  logic [IdxW-1:0]     dirty_set_slot
);

  logic [NumSlots-1:0] valid_r;
  logic [NumSlots-1:0] hit_vec_s;
  logic [TagWidth-1:0] tag_r [NumSlots];
  logic [IdxW-1:0]     ptr_r;
  logic [IdxW-1:0]     inv_idx_s;
  logic                have_inv_s;

  // Descending scan so the lowest matching / lowest invalid index wins.
  always_comb begin
    hit_vec_s  = '0;
    hit_idx    = '0;
    inv_idx_s  = '0;
    have_inv_s = 1'b0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      hit_vec_s[i] = valid_r[i] && (tag_r[i] == lookup_tag);
      hit_idx      = hit_vec_s[i] ? IdxW'(i) : hit_idx;
      inv_idx_s    = valid_r[i] ? inv_idx_s : IdxW'(i);
      have_inv_s   = have_inv_s | ~valid_r[i];
    end
    hit = |hit_vec_s;
  end

  assign victim_idx    = have_inv_s ? inv_idx_s : ptr_r;
  assign victim_tag    = tag_r[victim_idx];
  assign victim_is_ptr = (victim_idx == ptr_r);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= '0;
      ptr_r   <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      // Grant and done may share a cycle: the refill must win over the invalidate.
      if (inval_en) valid_r[inval_slot] <= 1'b0;
      if (fill_en) begin
        valid_r[fill_slot] <= 1'b1;
        tag_r[fill_slot]   <= fill_tag;
      end
      if (fill_en && fill_adv_ptr) ptr_r <= ptr_r + IdxW'(1);
    end
  end

`ifdef BLOCK_SWAP_DIRTY_EN
  logic [NumSlots-1:0] dirty_r;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dirty_r <= '0;
    end else if (fill_en) begin
      dirty_r[fill_slot] <= 1'b0;
    end else if (dirty_set_en) begin
      dirty_r[dirty_set_slot] <= 1'b1;
    end
  end

  assign victim_wb = valid_r[victim_idx] & dirty_r[victim_idx];
`else
  logic unused_dirty_s;
  assign unused_dirty_s = ^{dirty_set_en, dirty_set_slot};
  assign victim_wb      = valid_r[victim_idx];
`endif

  block_swap_ctrl_chk #(.NumSlots(NumSlots), .TagWidth(TagWidth)) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid   (valid_r),
    .tags    (tag_r),
    .hit_vec (hit_vec_s)
  );

endmodule

// File: rtl/block_swap_ctrl.sv
// Block-swap controller: resolves requests to SRAM slots and runs evict/fetch swaps on a miss.
// Optional BLOCK_SWAP_DIRTY_EN: only dirty victims are written back.
module block_swap_ctrl import block_swap_ctrl_pkg::*; #(
  parameter int NumSlots = NUM_SRAM_ADDRESSES,
  parameter int TagWidth = BLOCK_TAG_W
) (
  input logic              clk_i,
  input logic              rst_ni,
  block_swap_ctrl_if.slave bus
);

  localparam int IdxW = $clog2(NumSlots);

  swap_state_e         state_r, state_s;
  swap_cmd_t           cmd_r, cmd_s;
  logic                adv_r, adv_s;
  logic                swap_req_r, busy_r;
  logic                hit_s, victim_wb_s, victim_is_ptr_s;
  logic [IdxW-1:0]     hit_idx_s, victim_idx_s;
  logic [TagWidth-1:0] victim_tag_s;
  logic                inval_en_s, fill_en_s, dirty_set_en_s;

  block_swap_tag_table #(.NumSlots(NumSlots), .TagWidth(TagWidth)) u_table (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .lookup_tag     (bus.req_tag_i),
    .hit            (hit_s),
    .hit_idx        (hit_idx_s),
    .victim_idx     (victim_idx_s),
    .victim_wb      (victim_wb_s),
    .victim_tag     (victim_tag_s),
    .victim_is_ptr  (victim_is_ptr_s),
    .inval_en       (inval_en_s),
    .inval_slot     (cmd_r.slot),
    .fill_en        (fill_en_s),
    .fill_slot      (cmd_r.slot),
    .fill_tag       (cmd_r.fetch_tag),
    .fill_adv_ptr   (adv_r),
    .dirty_set_en   (dirty_set_en_s),
    .dirty_set_slot (hit_idx_s)
  );

  // Only a write that actually completes on an unblocked hit marks the slot dirty.
  assign dirty_set_en_s = bus.req_valid_i & bus.req_we_i & bus.req_gnt_i & hit_s
                        & (state_r == ST_IDLE);

  always_comb begin
    state_s    = state_r;
    cmd_s      = cmd_r;
    adv_s      = adv_r;
    inval_en_s = 1'b0;
    fill_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid_i && !hit_s) begin
          cmd_s.fetch_tag = bus.req_tag_i;
          cmd_s.slot      = victim_idx_s;
          cmd_s.wb_tag    = victim_tag_s;
          cmd_s.wb        = victim_wb_s;
          adv_s           = victim_is_ptr_s;
          state_s         = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.swap_gnt_i) begin
          inval_en_s = 1'b1;
          fill_en_s  = bus.swap_done_i;
          state_s    = bus.swap_done_i ? ST_IDLE : ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.swap_done_i) begin
          fill_en_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      cmd_r      <= '0;
      adv_r      <= 1'b0;
      swap_req_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cmd_r      <= cmd_s;
      adv_r      <= adv_s;
      swap_req_r <= (state_s == ST_REQ);
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  // Combinational so a miss is blocked in the same cycle it is presented.
  assign bus.block_o = (state_r != ST_IDLE) | (bus.req_valid_i & ~hit_s);

  always_comb begin
    bus.slot_idx_o = '0;
    if (!bus.req_valid_i) begin
      bus.slot_idx_o = '0;
    end else if (hit_s) begin
      bus.slot_idx_o = hit_idx_s;
    end else begin
      bus.slot_idx_o = cmd_r.slot;
    end
  end

  assign bus.swap_req_o       = swap_req_r;
  assign bus.swap_wb_o        = cmd_r.wb;
  assign bus.swap_wb_tag_o    = cmd_r.wb_tag;
  assign bus.swap_fetch_tag_o = cmd_r.fetch_tag;
  assign bus.swap_slot_o      = cmd_r.slot;
  assign bus.busy_o           = busy_r;

endmodule

// File: tb/tb_block_swap_ctrl.sv
// Self-checking bench for block_swap_ctrl against a slot-table reference model.
module tb_block_swap_ctrl;
  import block_swap_ctrl_pkg::*;

  localparam int NS = NUM_SRAM_ADDRESSES;

  logic clk;
  logic rst_n;
  int   cmp_cnt;
  int   err_cnt;

  slot_entry_t mdl [NS];
  int          mdl_ptr;

  block_swap_ctrl_if bus ();

  block_swap_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void mdl_clear();
    for (int i = 0; i < NS; i++) mdl[i] = '0;
    mdl_ptr = 0;
  endfunction

  function automatic bit mdl_hit(input logic [BLOCK_TAG_W-1:0] tag, output int idx);
    mdl_hit = 1'b0;
    idx     = 0;
    for (int i = 0; i < NS; i++) begin
      if (mdl[i].valid && mdl[i].tag == tag) begin
        mdl_hit = 1'b1;
        idx     = i;
      end
    end
  endfunction

  function automatic int mdl_victim();
    for (int i = 0; i < NS; i++) begin
      if (!mdl[i].valid) return i;
    end
    return mdl_ptr;
  endfunction

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.req_tag_i   = '0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_gnt_i   = 1'b0;
    bus.swap_gnt_i  = 1'b0;
    bus.swap_done_i = 1'b0;
    mdl_clear();
    repeat (3) @(negedge clk);
  endtask

  // One manager access; a miss is driven through the full swap handshake.
  task automatic access(input logic [BLOCK_TAG_W-1:0] tag, input bit we, input int gnt_wait,
                        input bit same_cycle, input int done_dly, input bit drop_mid);
    int  hidx;
    int  v;
    int  k;
    bit  exp_wb;
    bus.req_tag_i   = tag;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_gnt_i   = 1'b0;
    @(negedge clk);
    if (!mdl_hit(tag, hidx)) begin
      cmp_cnt++;
      if (bus.block_o !== 1'b1) begin
        err_cnt++; $display("FAIL miss_block tag=%h: block_o=%b required 1", tag, bus.block_o);
      end
      v = mdl_victim();
`ifdef BLOCK_SWAP_DIRTY_EN
      exp_wb = mdl[v].valid & mdl[v].dirty;
`else
      exp_wb = mdl[v].valid;
`endif
      k = 0;
      while (bus.swap_req_o !== 1'b1 && k < 10) begin
        @(negedge clk);
        k++;
      end
      for (int c = 0; c <= gnt_wait; c++) begin
        if (c > 0) @(negedge clk);
        cmp_cnt++;
        if (bus.swap_req_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.block_o !== 1'b1) begin
          err_cnt++; $display("FAIL swap_req tag=%h c=%0d: req/busy/block=%b%b%b required 111",
                              tag, c, bus.swap_req_o, bus.busy_o, bus.block_o);
        end
        cmp_cnt++;
        if (bus.swap_slot_o !== SLOT_IDX_W'(v) || bus.swap_wb_o !== exp_wb ||
            bus.swap_fetch_tag_o !== tag || bus.slot_idx_o !== SLOT_IDX_W'(v)) begin
          err_cnt++; $display("FAIL swap_cmd tag=%h c=%0d: slot=%0d wb=%b fetch=%h idx=%0d required slot=%0d wb=%b fetch=%h",
                              tag, c, bus.swap_slot_o, bus.swap_wb_o, bus.swap_fetch_tag_o,
                              bus.slot_idx_o, v, exp_wb, tag);
        end
        if (exp_wb) begin
          cmp_cnt++;
          if (bus.swap_wb_tag_o !== mdl[v].tag) begin
            err_cnt++; $display("FAIL swap_wb_tag: got %h required %h", bus.swap_wb_tag_o, mdl[v].tag);
          end
        end
      end
      @(posedge clk); #1;
      bus.swap_gnt_i  = 1'b1;
      bus.swap_done_i = same_cycle;
      @(posedge clk); #1;
      bus.swap_gnt_i  = 1'b0;
      bus.swap_done_i = 1'b0;
      if (drop_mid) bus.req_valid_i = 1'b0;
      if (!same_cycle) begin
        @(negedge clk);
        cmp_cnt++;
        if (bus.swap_req_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.block_o !== 1'b1) begin
          err_cnt++; $display("FAIL wait_state: req/busy/block=%b%b%b required 011",
                              bus.swap_req_o, bus.busy_o, bus.block_o);
        end
        repeat (done_dly) @(negedge clk);
        @(posedge clk); #1;
        bus.swap_done_i = 1'b1;
        @(posedge clk); #1;
        bus.swap_done_i = 1'b0;
      end
      mdl[v] = '{valid: 1'b1, dirty: 1'b0, tag: tag};
      if (v == mdl_ptr) mdl_ptr = (mdl_ptr + 1) % NS;
      hidx = v;
      if (drop_mid) begin
        #1;
        cmp_cnt++;
        if (bus.busy_o !== 1'b0 || bus.block_o !== 1'b0 || bus.slot_idx_o !== '0) begin
          err_cnt++; $display("FAIL drop_mid: busy=%b block=%b idx=%0d required 0 0 0",
                              bus.busy_o, bus.block_o, bus.slot_idx_o);
        end
        bus.req_valid_i = 1'b1;
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (bus.block_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.slot_idx_o !== SLOT_IDX_W'(hidx)) begin
      err_cnt++; $display("FAIL hit tag=%h: block=%b busy=%b idx=%0d required 0 0 %0d",
                          tag, bus.block_o, bus.busy_o, bus.slot_idx_o, hidx);
    end
    bus.req_gnt_i = 1'b1;
    @(posedge clk); #1;
    if (we) mdl[hidx].dirty = 1'b1;
    bus.req_gnt_i   = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cmp_cnt++;
    if (bus.block_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.swap_req_o !== 1'b0 ||
        bus.slot_idx_o !== '0 || bus.swap_slot_o !== '0 || bus.swap_wb_o !== 1'b0 ||
        bus.swap_fetch_tag_o !== '0 || bus.swap_wb_tag_o !== '0) begin
      err_cnt++; $display("FAIL reset_outputs: block=%b busy=%b req=%b idx=%0d slot=%0d wb=%b required all 0",
                          bus.block_o, bus.busy_o, bus.swap_req_o, bus.slot_idx_o, bus.swap_slot_o, bus.swap_wb_o);
    end
    bus.req_tag_i   = 21'h00010;
    bus.req_valid_i = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.block_o !== 1'b1) begin
      err_cnt++; $display("FAIL reset_all_miss: block_o=%b required 1", bus.block_o);
    end
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_miss();
    access(21'h00010, 1'b0, 0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_fill_evict();
    for (int t = 'h11; t <= 'h17; t++) access(BLOCK_TAG_W'(t), 1'b0, 0, 1'b0, 0, 1'b0);
    access(21'h00020, 1'b0, 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_dirty_wb();
    access(21'h00011, 1'b1, 0, 1'b0, 0, 1'b0);
    access(21'h00021, 1'b0, 0, 1'b0, 0, 1'b0);
    access(21'h00022, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_gnt_stall();
    access(21'h00023, 1'b0, 5, 1'b0, 2, 1'b0);
    access(21'h00024, 1'b0, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_ptr_wrap();
    for (int t = 'h25; t <= 'h28; t++) access(BLOCK_TAG_W'(t), 1'b0, 0, 1'b0, 0, 1'b0);
    access(21'h00017, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      access(BLOCK_TAG_W'(32'h30 + $urandom_range(11)), 1'($urandom_range(1)),
             $urandom_range(2), 1'($urandom_range(1)), $urandom_range(3),
             ($urandom_range(5) == 0));
    end
  endtask

  task automatic test_reset_mid_swap();
    int k;
    bus.req_tag_i   = 21'h00040;
    bus.req_valid_i = 1'b1;
    k = 0;
    @(negedge clk);
    while (bus.swap_req_o !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    cmp_cnt++;
    if (bus.swap_req_o !== 1'b1) begin
      err_cnt++; $display("FAIL rst_swap_req: swap_req_o=%b required 1", bus.swap_req_o);
    end
    @(posedge clk); #1;
    bus.swap_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.swap_gnt_i  = 1'b0;
    bus.req_valid_i = 1'b0;
    rst_n           = 1'b0;
    #1;
    cmp_cnt++;
    if (bus.busy_o !== 1'b0 || bus.swap_req_o !== 1'b0 || bus.swap_slot_o !== '0) begin
      err_cnt++; $display("FAIL rst_mid_wait: busy=%b req=%b slot=%0d required 0 0 0",
                          bus.busy_o, bus.swap_req_o, bus.swap_slot_o);
    end
    mdl_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.swap_done_i = 1'b1;
    @(posedge clk); #1;
    bus.swap_done_i = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (bus.busy_o !== 1'b0 || bus.swap_req_o !== 1'b0) begin
      err_cnt++; $display("FAIL stray_done: busy=%b req=%b required 0 0", bus.busy_o, bus.swap_req_o);
    end
    bus.req_tag_i   = 21'h00011;
    bus.req_valid_i = 1'b1;
    #1;
    cmp_cnt++;
    if (bus.block_o !== 1'b1) begin
      err_cnt++; $display("FAIL table_cleared: block_o=%b required 1", bus.block_o);
    end
    access(21'h00011, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_first_miss();
    test_fill_evict();
    test_dirty_wb();
    test_gnt_stall();
    test_ptr_wrap();
    test_random();
    test_reset_mid_swap();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
